uart_packet_wrapper_rx: RTL

Receive-side packet deframer for the FPGA↔ESP32 UART link. It consumes bytes from the UART receiver and hunts for the 0x8F magic header. It then parses address, count, data and a CRC-8 (SAE J1850) trailer. Data bytes are presented as indexed write strobes to the register/menu logic, and a per-packet done/CRC verdict lets consumers commit or discard.

---
 rtl/uart_packet_pkg.sv | 31 +++
 rtl/uart_packet_wrapper_rx.sv | 137 +++++++++++++
 2 files changed

// File: rtl/uart_packet_pkg.sv
// Shared definitions for the ESP32 UART packet link.
// Framing constants, rx state encoding and the byte-wide CRC-8 (J1850 poly).
package uart_packet_pkg;

  localparam logic [7:0] UART_MAGIC    = 8'h8F;
  localparam logic [7:0] CRC8_POLY     = 8'h1D;
  localparam logic [7:0] CRC8_SEED     = 8'hFF;
  localparam logic [7:0] CRC8_SEED_HDR = 8'h59;

  typedef enum logic [2:0] {
    RX_HUNT,
    RX_ADDR,
    RX_COUNT,
    RX_DATA,
    RX_CRC
  } rx_state_e;

  function automatic logic [7:0] crc8_update(
    input logic [7:0] crc,
    input logic [7:0] data
  );
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY)
               : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_packet_wrapper_rx.sv
// Receive-side packet deframer: magic hunt, addr/count/data/CRC parse.
// Payload bytes are strobed speculatively; done + crc verdict commits.
module uart_packet_wrapper_rx
  import uart_packet_pkg::*;
#(
  parameter int              TO_W           = 16,
  parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] uart_rx_data,
  input  logic       uart_rx_val,
  input  logic       uartDisabled,
  output logic [6:0] rx_address,
  output logic [7:0] rx_byteCount,
  output logic [7:0] rx_bytepos,
  output logic [7:0] rx_data,
  output logic       rx_data_val,
  output logic       rx_packet_done,
  output logic       rx_crc_ok,
  output logic       rx_crc_err,
  output logic       rx_frame_err,
  output logic       busy
);

  localparam logic [TO_W-1:0] TO_LAST =
    TIMEOUT_CYCLES - {{(TO_W-1){1'b0}}, 1'b1};

  rx_state_e       state;
  logic [8:0]      remaining;
  logic [7:0]      pos;
  logic [7:0]      crc_a;
  logic [7:0]      crc_b;
  logic [TO_W-1:0] to_cnt;
  logic            crc_hit;

  assign busy    = (state != RX_HUNT);
  assign crc_hit = (uart_rx_data == crc_a) ||
                   (uart_rx_data == crc_b);

  // Packet FSM, CRC accumulators, inter-byte timeout and output strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= RX_HUNT;
      remaining      <= '0;
      pos            <= '0;
      crc_a          <= CRC8_SEED_HDR;
      crc_b          <= CRC8_SEED;
      to_cnt         <= '0;
      rx_address     <= '0;
      rx_byteCount   <= '0;
      rx_bytepos     <= '0;
      rx_data        <= '0;
      rx_data_val    <= 1'b0;
      rx_packet_done <= 1'b0;
      rx_crc_ok      <= 1'b0;
      rx_crc_err     <= 1'b0;
      rx_frame_err   <= 1'b0;
    end else begin
      rx_data_val    <= 1'b0;
      rx_packet_done <= 1'b0;
      rx_crc_ok      <= 1'b0;
      rx_crc_err     <= 1'b0;
      rx_frame_err   <= 1'b0;
      if (uartDisabled) begin
        state  <= RX_HUNT;
        to_cnt <= '0;
      end else if (uart_rx_val) begin
        to_cnt <= '0;
        unique case (state)
          RX_HUNT: begin
            if (uart_rx_data == UART_MAGIC) begin
              state <= RX_ADDR;
              crc_a <= CRC8_SEED_HDR;
              crc_b <= CRC8_SEED;
            end
          end
          RX_ADDR: begin
            if (uart_rx_data[7]) begin
              rx_frame_err <= 1'b1;
              // a fresh magic byte restarts the packet immediately
              if (uart_rx_data == UART_MAGIC) begin
                state <= RX_ADDR;
                crc_a <= CRC8_SEED_HDR;
                crc_b <= CRC8_SEED;
              end else begin
                state <= RX_HUNT;
              end
            end else begin
              rx_address <= uart_rx_data[6:0];
              crc_a      <= crc8_update(crc_a, uart_rx_data);
              crc_b      <= crc8_update(crc_b, uart_rx_data);
              state      <= RX_COUNT;
            end
          end
          RX_COUNT: begin
            rx_byteCount <= uart_rx_data;
            remaining    <= (uart_rx_data == 8'd0) ? 9'd256
                                                   : {1'b0, uart_rx_data};
            pos          <= '0;
            crc_a        <= crc8_update(crc_a, uart_rx_data);
            crc_b        <= crc8_update(crc_b, uart_rx_data);
            state        <= RX_DATA;
          end
          RX_DATA: begin
            rx_data     <= uart_rx_data;
            rx_bytepos  <= pos;
            rx_data_val <= 1'b1;
            pos         <= pos + 8'd1;
            remaining   <= remaining - 9'd1;
            crc_a       <= crc8_update(crc_a, uart_rx_data);
            crc_b       <= crc8_update(crc_b, uart_rx_data);
            if (remaining == 9'd1) begin
              state <= RX_CRC;
            end
          end
          RX_CRC: begin
            rx_packet_done <= 1'b1;
            rx_crc_ok      <= crc_hit;
            rx_crc_err     <= !crc_hit;
            state          <= RX_HUNT;
          end
          default: state <= RX_HUNT;
        endcase
      end else if (busy) begin
        if (to_cnt == TO_LAST) begin
          rx_frame_err <= 1'b1;
          state        <= RX_HUNT;
          to_cnt       <= '0;
        end else begin
          to_cnt <= to_cnt + {{(TO_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

endmodule
